// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared encodings and state type for the AHB-to-SRAM byte-serial front end
package ahb_sram_pkg;
  localparam int SRAM_ADDR_WIDTH_DEFAULT = 12;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_ERR1, ST_ERR2} state_t;
  function automatic logic [2:0] size_bytes(input logic [2:0] hsize);
    return 3'd1 << hsize[1:0];
  endfunction
endpackage

// File: rtl/sram_byte_seq.sv
// sram_byte_seq: walks the byte lanes of one beat, producing a registered one-hot-low lane strobe
module sram_byte_seq (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       start,
  input  logic [2:0] n,
  input  logic [1:0] l0,
  output logic [3:0] lane_n,
  output logic [1:0] idx,
  output logic       last,
  output logic       done
);
  logic       active;
  logic [1:0] k;
  logic [2:0] n_q;
  assign last = active && ({1'b0, k} == n_q - 3'd1);
  // Lane walker: load on start, shift the strobe one lane up per cycle, drop it after the last byte
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      active <= 1'b0;
      k      <= 2'd0;
      n_q    <= 3'd0;
      idx    <= 2'd0;
      lane_n <= 4'hF;
      done   <= 1'b0;
    end else begin
      done <= last && !start;
      if (start) begin
        active <= 1'b1;
        k      <= 2'd0;
        n_q    <= n;
        idx    <= l0;
        lane_n <= ~(4'b0001 << l0);
      end else if (last) begin
        active <= 1'b0;
        k      <= 2'd0;
        lane_n <= 4'hF;
      end else if (active) begin
        k      <= k + 2'd1;
        idx    <= idx + 2'd1;
        lane_n <= {lane_n[2:0], 1'b1};
      end
    end
  end
endmodule

// File: rtl/ahb_sram_if.sv
// ahb_sram_if: AHB-Lite slave that splits each beat into byte-serial accesses on the SRAM bank array
module ahb_sram_if
  import ahb_sram_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEFAULT,
  parameter int SRAM_DATA_WIDTH = 32
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  input  logic                       hsel,
  input  logic [1:0]                 htrans,
  input  logic                       hwrite,
  input  logic [2:0]                 hsize,
  input  logic [31:0]                haddr,
  input  logic [SRAM_DATA_WIDTH-1:0] hwdata,
  input  logic                       hready,
  output logic                       hreadyout,
  output logic                       hresp,
  output logic [SRAM_DATA_WIDTH-1:0] hrdata,
  output logic [3:0]                 sram_cb_n,
  output logic [3:0]                 sram_cs_n,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_write_n,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata
);
  state_t                     state, state_nx;
  logic                       accept, err_in, start, seq_last, seq_done, rd_vld, unused;
  logic [1:0]                 idx, rd_idx;
  logic [3:0]                 lane_n;
  logic [SRAM_DATA_WIDTH-1:0] rbuf, rd_merged, hrdata_q;
  assign accept = hsel && htrans[1] && hready && hreadyout;
  assign err_in = hsize > HSIZE_WORD || (hsize == HSIZE_HALF && haddr[0]) ||
                  (hsize == HSIZE_WORD && haddr[1:0] != 2'b00);
  assign start = accept && !err_in;
  assign sram_cb_n = lane_n;
  assign sram_cs_n = lane_n;
  assign sram_wdata = sram_write_n ? '0 : {(SRAM_DATA_WIDTH/8){hwdata[{idx, 3'b000} +: 8]}};
  assign hrdata = (state == ST_RD && seq_done) ? rd_merged : hrdata_q;
  assign unused = ^{htrans[0], haddr[31:SRAM_ADDR_WIDTH+2], sram_rdata[SRAM_DATA_WIDTH-1:8]};
  sram_byte_seq u_seq (
    .hclk   (hclk),
    .hresetn(hresetn),
    .start  (start),
    .n      (size_bytes(hsize)),
    .l0     (haddr[1:0]),
    .lane_n (lane_n),
    .idx    (idx),
    .last   (seq_last),
    .done   (seq_done)
  );
  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= ST_IDLE;
    else state <= state_nx;
  end
  // Next state: hold while stalled (ERR1 always advances), otherwise follow the captured address phase
  always_comb begin
    state_nx = !hreadyout ? (state == ST_ERR1 ? ST_ERR2 : state) :
               !accept ? ST_IDLE : err_in ? ST_ERR1 : hwrite ? ST_WR : ST_RD;
  end
  // AHB response: writes finish on the last byte, reads one cycle later, errors take two cycles
  always_comb begin
    hreadyout = state == ST_WR ? seq_last : state == ST_RD ? seq_done : state != ST_ERR1;
    hresp     = state == ST_ERR1 || state == ST_ERR2;
  end
  // Returning read byte lands in the lane issued the cycle before
  always_comb begin
    rd_merged = rbuf;
    if (rd_vld) rd_merged[{rd_idx, 3'b000} +: 8] = sram_rdata[7:0];
  end
  // SRAM strobe/address registers, read byte assembly and the held read result
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sram_write_n <= 1'b1;
      sram_addr    <= '0;
      rd_vld       <= 1'b0;
      rd_idx       <= 2'd0;
      rbuf         <= '0;
      hrdata_q     <= '0;
    end else begin
      rd_vld <= lane_n != 4'hF && sram_write_n;
      rd_idx <= idx;
      rbuf   <= (start && !hwrite) ? '0 : rd_merged;
      if (state == ST_RD && seq_done) hrdata_q <= rd_merged;
      if (start) begin
        sram_write_n <= !hwrite;
        sram_addr    <= haddr[SRAM_ADDR_WIDTH+1:2];
      end else if (seq_last) begin
        sram_write_n <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_if.sv
// tb_ahb_sram_if: directed self-checking bench with a behavioural four-bank byte SRAM
module tb_ahb_sram_if;
  logic        hclk = 1'b0, hresetn = 1'b0, hsel = 1'b0, hwrite = 1'b0;
  logic [1:0]  htrans = 2'd0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] haddr = 32'h0, hwdata = 32'h0;
  logic        hready, hreadyout, hresp, sram_write_n;
  logic [31:0] hrdata, sram_wdata;
  logic [31:0] sram_rdata = 32'h0;
  logic [3:0]  sram_cb_n, sram_cs_n;
  logic [11:0] sram_addr;
  int          checks = 0, errors = 0;
  logic [7:0]  mem [4][4096];
  logic [3:0]  log_cb [8], log_cs [8];
  logic [31:0] log_wd [8];
  logic        log_wn [8], log_rdy [8], log_resp [8];
  logic [11:0] log_addr [8];
  int          nwait;
  logic [31:0] rd_last;

  assign hready = hreadyout;
  always #5 hclk = ~hclk;

  ahb_sram_if dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .sram_cb_n(sram_cb_n), .sram_cs_n(sram_cs_n),
    .sram_addr(sram_addr), .sram_write_n(sram_write_n), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // Bank array model: per-lane write, read data returned the following cycle on [7:0]
  always @(posedge hclk) begin
    for (int l = 0; l < 4; l++) begin
      if (!sram_cb_n[l]) begin
        if (!sram_write_n) mem[l][sram_addr] <= sram_wdata[8*l +: 8];
        else sram_rdata <= {24'h0, mem[l][sram_addr]};
      end
    end
  end

  task automatic xfer(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic fin;
    n = 0;
    fin = 1'b0;
    hsel = 1'b1; htrans = 2'd2; hwrite = w; hsize = sz; haddr = a;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = wd;
    nwait = 0;
    while (!fin && n < 8) begin
      @(negedge hclk);
      log_cb[n] = sram_cb_n; log_cs[n] = sram_cs_n; log_wd[n] = sram_wdata;
      log_wn[n] = sram_write_n; log_rdy[n] = hreadyout; log_resp[n] = hresp; log_addr[n] = sram_addr;
      n++;
      fin = hreadyout;
      rd_last = hrdata;
      if (!fin) nwait++;
      @(posedge hclk); #1;
    end
    hwdata = 32'h0;
    checks++;
    if (!fin) begin errors++; $display("FAIL xfer_timeout addr=%h hreadyout never rose", a); end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({hreadyout, hresp, sram_write_n} !== 3'b101) begin
      errors++; $display("FAIL reset_ctrl got rdy/resp/wn=%b exp=101", {hreadyout, hresp, sram_write_n});
    end
    checks++;
    if ({sram_cb_n, sram_cs_n} !== 8'hFF) begin
      errors++; $display("FAIL reset_lanes got cb/cs=%h exp=ff", {sram_cb_n, sram_cs_n});
    end
    checks++;
    if ({hrdata, sram_wdata, sram_addr} !== 76'h0) begin
      errors++; $display("FAIL reset_data got hrdata=%h wdata=%h addr=%h exp 0", hrdata, sram_wdata, sram_addr);
    end
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
  endtask

  task automatic test_word_rw;
    xfer(1'b1, 3'd2, 32'h10, 32'hA1B2C3D4);
    checks++;
    if (nwait !== 3) begin errors++; $display("FAIL word_wr_waits got=%0d exp=3", nwait); end
    checks++;
    if ({log_cb[0], log_cb[1], log_cb[2], log_cb[3]} !== 16'hEDB7 ||
        {log_cs[0], log_cs[1], log_cs[2], log_cs[3]} !== 16'hEDB7) begin
      errors++; $display("FAIL word_wr_lanes got cb=%h%h%h%h exp=edb7", log_cb[0], log_cb[1], log_cb[2], log_cb[3]);
    end
    checks++;
    if ({log_wd[0], log_wd[1], log_wd[2], log_wd[3]} !== 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1) begin
      errors++; $display("FAIL word_wr_data got=%h %h %h %h exp=d4.. c3.. b2.. a1..", log_wd[0], log_wd[1], log_wd[2], log_wd[3]);
    end
    checks++;
    if ({log_wn[0], log_wn[1], log_wn[2], log_wn[3], log_addr[0]} !== {4'b0000, 12'h004}) begin
      errors++; $display("FAIL word_wr_ctl got wn=%b%b%b%b addr=%h exp wn=0000 addr=004",
                         log_wn[0], log_wn[1], log_wn[2], log_wn[3], log_addr[0]);
    end
    xfer(1'b0, 3'd2, 32'h10, 32'h0);
    checks++;
    if (nwait !== 4) begin errors++; $display("FAIL word_rd_waits got=%0d exp=4", nwait); end
    checks++;
    if (rd_last !== 32'hA1B2C3D4) begin errors++; $display("FAIL word_rd_data got=%h exp=a1b2c3d4", rd_last); end
    checks++;
    if ({log_cb[0], log_cb[1], log_cb[2], log_cb[3], log_cb[4], log_wn[0]} !== {20'hEDB7F, 1'b1}) begin
      errors++; $display("FAIL word_rd_lanes got cb=%h%h%h%h%h wn=%b exp=edb7f wn=1",
                         log_cb[0], log_cb[1], log_cb[2], log_cb[3], log_cb[4], log_wn[0]);
    end
  endtask

  task automatic test_byte;
    xfer(1'b1, 3'd0, 32'h13, 32'h55000000);
    checks++;
    if ({nwait[3:0], log_cb[0], log_wd[0]} !== {4'd0, 4'h7, 32'h55555555}) begin
      errors++; $display("FAIL byte_wr got waits=%0d cb=%h wdata=%h exp 0 7 55555555", nwait, log_cb[0], log_wd[0]);
    end
    xfer(1'b0, 3'd0, 32'h13, 32'h0);
    checks++;
    if (nwait !== 1 || rd_last !== 32'h55000000) begin
      errors++; $display("FAIL byte_rd got waits=%0d hrdata=%h exp 1 55000000", nwait, rd_last);
    end
  endtask

  task automatic test_halfword;
    xfer(1'b1, 3'd2, 32'h20, 32'h11223344);
    xfer(1'b1, 3'd1, 32'h22, 32'hBEEF0000);
    checks++;
    if (nwait !== 1 || {log_cb[0], log_cb[1]} !== 8'hB7) begin
      errors++; $display("FAIL half_wr_lanes got waits=%0d cb=%h%h exp 1 b7", nwait, log_cb[0], log_cb[1]);
    end
    checks++;
    if ({log_wd[0], log_wd[1]} !== 64'hEFEFEFEF_BEBEBEBE) begin
      errors++; $display("FAIL half_wr_data got=%h %h exp=efefefef bebebebe", log_wd[0], log_wd[1]);
    end
    checks++;
    if (rd_last !== 32'h55000000) begin errors++; $display("FAIL hrdata_hold got=%h exp=55000000", rd_last); end
    xfer(1'b0, 3'd2, 32'h20, 32'h0);
    checks++;
    if (rd_last !== 32'hBEEF3344) begin errors++; $display("FAIL half_word_rd got=%h exp=beef3344", rd_last); end
    xfer(1'b0, 3'd1, 32'h22, 32'h0);
    checks++;
    if (nwait !== 2 || rd_last !== 32'hBEEF0000) begin
      errors++; $display("FAIL half_rd got waits=%0d hrdata=%h exp 2 beef0000", nwait, rd_last);
    end
  endtask

  task automatic test_idle_busy;
    logic [2:0] pat [3];
    pat[0] = {1'b1, 2'd1};
    pat[1] = {1'b1, 2'd0};
    pat[2] = {1'b0, 2'd2};
    hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      {hsel, htrans} = pat[i];
      @(posedge hclk); #1;
      @(negedge hclk);
      checks++;
      if ({hreadyout, hresp, sram_cb_n, sram_write_n} !== {1'b1, 1'b0, 4'hF, 1'b1}) begin
        errors++; $display("FAIL idle_busy_%0d got rdy=%b resp=%b cb=%h wn=%b exp 1 0 f 1",
                           i, hreadyout, hresp, sram_cb_n, sram_write_n);
      end
      @(posedge hclk); #1;
    end
    hsel = 1'b0; htrans = 2'd0;
  endtask

  task automatic test_errors;
    logic [2:0] sz [2];
    logic [31:0] ad [2];
    sz[0] = 3'd1; ad[0] = 32'h01;
    sz[1] = 3'd3; ad[1] = 32'h40;
    for (int i = 0; i < 2; i++) begin
      xfer(1'b1, sz[i], ad[i], 32'hFFFFFFFF);
      checks++;
      if (nwait !== 1 || {log_rdy[0], log_resp[0], log_rdy[1], log_resp[1]} !== 4'b0111) begin
        errors++; $display("FAIL err_resp_%0d got waits=%0d rdy/resp=%b%b%b%b exp 1 0111",
                           i, nwait, log_rdy[0], log_resp[0], log_rdy[1], log_resp[1]);
      end
      checks++;
      if ({log_cs[0], log_cs[1], log_wn[0], log_wn[1]} !== {8'hFF, 2'b11}) begin
        errors++; $display("FAIL err_no_access_%0d got cs=%h%h wn=%b%b exp ff 11", i, log_cs[0], log_cs[1], log_wn[0], log_wn[1]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int wc, rc;
    logic fin;
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(posedge hclk); #1;
    hwdata = 32'hCAFEF00D; hwrite = 1'b0;
    wc = 0; fin = 1'b0;
    while (!fin && wc < 8) begin
      @(negedge hclk);
      wc++;
      fin = hreadyout;
      @(posedge hclk); #1;
    end
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h0;
    checks++;
    if (wc !== 4) begin errors++; $display("FAIL b2b_write_cycles got=%0d exp=4", wc); end
    @(negedge hclk);
    checks++;
    if ({sram_cb_n, sram_write_n, hreadyout} !== {4'hE, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_read_start got cb=%h wn=%b rdy=%b exp e 1 0", sram_cb_n, sram_write_n, hreadyout);
    end
    rc = 1; fin = hreadyout;
    while (!fin && rc < 8) begin
      @(posedge hclk); #1;
      @(negedge hclk);
      rc++;
      fin = hreadyout;
    end
    checks++;
    if (rc !== 5 || hrdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b2b_read got cycles=%0d hrdata=%h exp 5 cafef00d", rc, hrdata);
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_reset_mid;
    xfer(1'b1, 3'd2, 32'h50, 32'h11111111);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h50;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'hDDCCBBAA;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    checks++;
    if (sram_cb_n !== 4'hB) begin errors++; $display("FAIL rst_mid_pre got cb=%h exp=b", sram_cb_n); end
    hresetn = 1'b0;
    #1;
    checks++;
    if ({hreadyout, hresp, sram_write_n, sram_cb_n, sram_cs_n} !== {3'b101, 8'hFF}) begin
      errors++; $display("FAIL rst_mid_ctrl got rdy/resp/wn=%b%b%b cb=%h cs=%h exp 101 f f",
                         hreadyout, hresp, sram_write_n, sram_cb_n, sram_cs_n);
    end
    checks++;
    if ({hrdata, sram_wdata, sram_addr} !== 76'h0) begin
      errors++; $display("FAIL rst_mid_data got hrdata=%h wdata=%h addr=%h exp 0", hrdata, sram_wdata, sram_addr);
    end
    @(posedge hclk); #1;
    hresetn = 1'b1; hwdata = 32'h0;
    @(posedge hclk); #1;
    xfer(1'b0, 3'd2, 32'h50, 32'h0);
    checks++;
    if (rd_last !== 32'h1111BBAA) begin errors++; $display("FAIL rst_mid_readback got=%h exp=1111bbaa", rd_last); end
  endtask

  initial begin
    test_reset;
    test_word_rw;
    test_byte;
    test_halfword;
    test_idle_busy;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/ahb_sram_if.md
# ahb_sram_if

AHB-Lite slave front end that converts AHB transfers into byte-serial accesses on the four-bank SRAM array (`sram_bank_top`). It sits directly upstream of the bank array and drives its `sram_*` inputs. Every AHB beat is split into one SRAM cycle per byte, because the array's read mux only returns data for a one-hot-low `sram_cb_n`. The block stalls the bus with `hreadyout` while the byte sequence runs.

## Interface
- `SRAM_ADDR_WIDTH`, default 12: SRAM word address width. Byte address range is 4·2^12 = 16 KB.
- `SRAM_DATA_WIDTH`, default 32: width of the AHB and SRAM data buses.
- `hclk`, input, 1: the single clock. It also clocks the SRAM array.
- `hresetn`, input, 1: asynchronous, active-low reset.
- `hsel`, input, 1: slave select.
- `htrans`, input, 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite`, input, 1: 1 = write.
- `hsize`, input, 3: 0 = byte, 1 = halfword, 2 = word. Any other value is an error.
- `haddr`, input, 32: byte address. Only bits [13:0] are used.
- `hwdata`, input, 32: write data, valid in the data phase.
- `hready`, input, 1: bus-level ready.
- `hreadyout`, output, 1: slave ready.
- `hresp`, output, 1: 0 = OKAY, 1 = ERROR.
- `hrdata`, output, 32: read data.
- `sram_cb_n`, output, 4: byte-lane select, one-hot-low during an access.
- `sram_cs_n`, output, 4: chip select. Always equal to `sram_cb_n`.
- `sram_addr`, output, SRAM_ADDR_WIDTH: word address, `haddr[13:2]`.
- `sram_write_n`, output, 1: 0 = write.
- `sram_wdata`, output, 32: the current byte replicated on all four lanes.
- `sram_rdata`, input, 32: array read data. Only `[7:0]` is meaningful. It is valid one cycle after the read is issued.

## Operation
- **Address-phase capture.** An address phase is accepted when `hsel & htrans[1] & hready`. On acceptance the block registers `hwrite`, the byte count N (`hsize`: 0→1, 1→2, 2→4), the start lane L0 = `haddr[1:0]`, and the word address.
- **Errors.** The transfer is an error if `hsize` > 2, or if the address is misaligned (`haddr[0]` set for a halfword, `haddr[1:0]` ≠ 0 for a word).
  - Errors use the standard two-cycle response: cycle 1 has `hresp`=1, `hreadyout`=0; cycle 2 has `hresp`=1, `hreadyout`=1.
  - No SRAM access is made for an error.
- **IDLE/BUSY.** An unselected slave, or an IDLE/BUSY transfer, gets a zero-wait OKAY response. The SRAM stays idle.
- **State machine** (states IDLE, WR, RD, ERR1, ERR2), with byte counter k in the range 0..N−1:
  - IDLE → WR or RD on an accepted valid transfer.
  - IDLE → ERR1 on an accepted error transfer. ERR1 → ERR2 → IDLE, or ERR2 goes straight to the next captured state if a new address phase is accepted in ERR2.
  - WR/RD → IDLE on completion, or → the next WR/RD/ERR1 if a pipelined address phase is accepted in the completing cycle.
- **Write, data-phase cycle k (k = 0..N−1):**
  - `sram_cb_n` = ~(1 << (L0+k)), `sram_write_n`=0.
  - `sram_wdata` = {4{hwdata[8(L0+k)+7 : 8(L0+k)]}}, taken combinationally from `hwdata`.
  - `hreadyout` = (k == N−1).
- **Read, data-phase cycle k (k = 0..N−1):**
  - Issue `sram_cb_n` = ~(1 << (L0+k)), `sram_write_n`=1.
  - In cycle k+1, capture `sram_rdata[7:0]` into lane L0+k of an internal byte register.
  - Cycle N is the completion cycle: no SRAM access, `hreadyout`=1, and `hrdata` = register with the last byte merged combinationally from `sram_rdata`. Lanes outside the access read as 0.
  - `hrdata` holds its value after completion until the next read completes.
- **Idle SRAM outputs.** When no access is in progress: `sram_cs_n` = `sram_cb_n` = 4'hF, `sram_write_n`=1, and `sram_addr` holds its last value.

## Timing
- **Reset values** (applied asynchronously):
  - `hreadyout`=1, `hresp`=0, `hrdata`=0.
  - `sram_cb_n` = `sram_cs_n` = 4'hF, `sram_write_n`=1, `sram_addr`=0, `sram_wdata`=0.
  - State = IDLE, k=0.
- **Output timing.** All SRAM control outputs come from registers. `sram_wdata` is the only combinational path from `hwdata`.
- **Wait states:**
  - Write: N−1.
  - Read: N (byte read 1, halfword 2, word 4).
  - Error: 1.
- **Pipelining.** A new address phase is accepted only in a cycle where `hreadyout`=1. Back-to-back transfers therefore add no idle cycles.
- **Reset mid-transfer.** The FSM returns to IDLE immediately. Bytes already written stay written. The remaining bytes are dropped, and no response is completed.

## Structure
- **Package `ahb_sram_pkg`:** HTRANS and HSIZE encodings, the state enum, and the SRAM_ADDR_WIDTH default.
- **Sub-module `sram_byte_seq`:** the lane/byte counter. Inputs: start, N, L0. Outputs: current one-hot-low lane, last, done.
- **Top level:** the FSM and the AHB response logic.

## Test plan
- **Word write then word read:** write `haddr`=0x10, 0xA1B2C3D4. Then read 0x10.
  - Write: 4 SRAM write cycles, lanes `cb_n` = E, D, B, 7, byte data D4, C3, B2, A1, 3 wait states.
  - Read: 4 wait states, `hrdata`=0xA1B2C3D4.
- **Byte write:**
  - Write 0x55 to 0x13: a single cycle with `cb_n`=7 and `sram_wdata`=0x55555555, zero wait.
  - Read back as a byte: `hrdata`=0x55000000.
- **Halfword at 0x22:** write 0xBEEF with `hwdata`=0xBEEF0000. Expect lanes B then 7. Word read of 0x20 returns 0xBEEFxxxx, with the existing low half unchanged.
- **Errors:** a halfword to 0x01, or `hsize`=3. Expect ERR1/ERR2 two-cycle ERROR, `cs_n` held at F throughout.
- **Back-to-back pipelining:** a write to 0x40 followed immediately by a read of 0x40. The second address phase is accepted in the write's completion cycle, with no extra idle cycle.
- **Reset mid-transfer:** assert `hresetn` during byte 2 of a word write. All outputs take their reset values in the same cycle. A subsequent read shows lanes 0–1 written and lanes 2–3 unchanged.
